// File: rtl/be_pkg.sv
// Shared back-end types for the multi-cycle RV32I core:
// mnemonics, controller state and mux-select encodings.
package be_pkg;

  localparam int MEM_TIMEOUT_DEF = 16;

  typedef enum logic [5:0] {
    ILLEGAL,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI,
    SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU,
    XOR, SRL, SRA, OR, AND,
    ECALL, EBREAK
  } RV32I_INSTRUCTION_MNEMONIC_t;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE,
    MEM, WRITEBACK, TRAP
  } ctrl_state_t;

  typedef enum logic {
    A_RS1, A_PC
  } alu_a_sel_t;

  typedef enum logic [1:0] {
    B_RS2, B_IMM, B_FOUR
  } alu_b_sel_t;

  typedef enum logic [1:0] {
    PC_PLUS4, PC_ALU, PC_BRANCH
  } pc_src_t;

  typedef enum logic [1:0] {
    WB_ALU, WB_MEM, WB_PC4
  } wb_sel_t;

  typedef enum logic [1:0] {
    CAUSE_NONE, CAUSE_ILLEGAL,
    CAUSE_BUS, CAUSE_HALT
  } trap_cause_t;

  function automatic logic is_load(
    input RV32I_INSTRUCTION_MNEMONIC_t m
  );
    return m inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic logic is_store(
    input RV32I_INSTRUCTION_MNEMONIC_t m
  );
    return m inside {SB, SH, SW};
  endfunction

  function automatic logic is_branch(
    input RV32I_INSTRUCTION_MNEMONIC_t m
  );
    return m inside {BEQ, BNE, BLT,
                     BGE, BLTU, BGEU};
  endfunction

  function automatic logic is_jump(
    input RV32I_INSTRUCTION_MNEMONIC_t m
  );
    return m inside {JAL, JALR};
  endfunction

  function automatic logic is_system(
    input RV32I_INSTRUCTION_MNEMONIC_t m
  );
    return m inside {ECALL, EBREAK};
  endfunction

  function automatic logic uses_imm(
    input RV32I_INSTRUCTION_MNEMONIC_t m
  );
    return m inside {LUI, AUIPC, JAL, JALR,
                     ADDI, SLTI, SLTIU, XORI,
                     ORI, ANDI, SLLI, SRLI,
                     SRAI}
        || is_load(m) || is_store(m);
  endfunction

endpackage

// File: rtl/rv32i_multicycle_ctrl_if.sv
// Unified memory-port handshake between the
// controller (master) and the memory (slave).
interface rv32i_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/bus_watchdog.sv
// Counts consecutive unacknowledged request cycles
// and flags expiry on the last allowed wait cycle.
module bus_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ready,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (active && !ready)
      cnt <= cnt + 8'd1;
    else
      cnt <= '0;
  end

  // ready on the final cycle wins over expiry
  assign expired = active && !ready
                && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences the shared
// ALU, register file and unified memory port.
module rv32i_multicycle_ctrl
  import be_pkg::*;
#(
  parameter int MEM_TIMEOUT   = MEM_TIMEOUT_DEF,
  parameter int INSTRET_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
  input  logic                        cond_jump,
  rv32i_multicycle_ctrl_if.master     mem,
  output logic                        ir_we,
  output logic                        ab_we,
  output logic                        alu_out_we,
  output alu_a_sel_t                  alu_a_sel,
  output alu_b_sel_t                  alu_b_sel,
  output logic                        pc_we,
  output pc_src_t                     pc_src,
  output logic                        reg_we,
  output wb_sel_t                     wb_sel,
  output ctrl_state_t                 state,
  output logic                        trap,
  output trap_cause_t                 trap_cause,
  output logic [INSTRET_WIDTH-1:0]    instret
);

  ctrl_state_t nxt;
  trap_cause_t nxt_cause;
  logic        retire;
  logic        expired;

  bus_watchdog #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (state == FETCH || state == MEM),
    .ready   (mem.mem_ready),
    .expired (expired)
  );

  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_we      = 1'b0;
    ab_we      = 1'b0;
    alu_out_we = 1'b0;
    alu_a_sel  = A_RS1;
    alu_b_sel  = B_RS2;
    pc_we      = 1'b0;
    pc_src     = PC_PLUS4;
    reg_we     = 1'b0;
    wb_sel     = WB_ALU;
    retire     = 1'b0;
    nxt        = state;
    nxt_cause  = CAUSE_NONE;
    unique case (state)
      IDLE:
        if (run) nxt = FETCH;
      FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_we = 1'b1;
          nxt   = DECODE;
        end else if (expired) begin
          nxt       = TRAP;
          nxt_cause = CAUSE_BUS;
        end
      end
      DECODE: begin
        ab_we = 1'b1;
        if (mnemonic == ILLEGAL) begin
          nxt       = TRAP;
          nxt_cause = CAUSE_ILLEGAL;
        end else begin
          nxt = EXECUTE;
        end
      end
      EXECUTE: begin
        alu_out_we = 1'b1;
        alu_a_sel  = (mnemonic == AUIPC ||
                      mnemonic == JAL)
                   ? A_PC : A_RS1;
        alu_b_sel  = uses_imm(mnemonic)
                   ? B_IMM : B_RS2;
        unique case (1'b1)
          is_branch(mnemonic): begin
            pc_we  = 1'b1;
            pc_src = cond_jump
                   ? PC_BRANCH : PC_PLUS4;
            retire = 1'b1;
            nxt    = FETCH;
          end
          is_load(mnemonic),
          is_store(mnemonic):
            nxt = MEM;
          is_system(mnemonic): begin
            nxt       = TRAP;
            nxt_cause = CAUSE_HALT;
          end
          default:
            nxt = WRITEBACK;
        endcase
      end
      MEM: begin
        mem.mem_req      = 1'b1;
        mem.mem_addr_sel = 1'b1;
        mem.mem_we       = is_store(mnemonic);
        if (mem.mem_ready) begin
          if (is_store(mnemonic)) begin
            pc_we  = 1'b1;
            retire = 1'b1;
            nxt    = FETCH;
          end else begin
            nxt = WRITEBACK;
          end
        end else if (expired) begin
          nxt       = TRAP;
          nxt_cause = CAUSE_BUS;
        end
      end
      WRITEBACK: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        nxt    = FETCH;
        unique case (1'b1)
          is_load(mnemonic):
            wb_sel = WB_MEM;
          is_jump(mnemonic): begin
            wb_sel = WB_PC4;
            pc_src = PC_ALU;
          end
          default:
            wb_sel = WB_ALU;
        endcase
      end
      TRAP: ;
      default:
        nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      trap       <= 1'b0;
      trap_cause <= CAUSE_NONE;
      instret    <= '0;
    end else begin
      state   <= nxt;
      instret <= instret
               + INSTRET_WIDTH'(retire);
      if (nxt == TRAP && state != TRAP) begin
        trap       <= 1'b1;
        trap_cause <= nxt_cause;
      end
    end
  end

endmodule

// File: doc/rv32i_multicycle_ctrl.md
Name: rv32i_multicycle_ctrl

Overview:
Control FSM for the multi-cycle RV32I core. The single shared ALU, register file and unified memory port are reused across cycles instead of being duplicated. The block sequences fetch, decode, execute, memory and writeback, and drives the operand-mux, PC, writeback and memory-handshake controls. It sits in the back-end beside the ALU, consumes the decoded mnemonic plus the ALU `cond_jump`, and raises traps on illegal instructions and bus timeouts.

Parameters:
- MEM_TIMEOUT, 16: max consecutive cycles `mem_req` may stay unacknowledged before a bus-timeout trap (2..255).
- INSTRET_WIDTH, 32: width of retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  leave IDLE and start fetching
- mnemonic  in  RV32I_INSTRUCTION_MNEMONIC_t  decoded IR contents; valid from DECODE onward
- cond_jump  in  1  ALU branch-taken flag; valid in EXECUTE
- mem_ready  in  1  memory acknowledge for current request
- mem_req  out  1  memory request
- mem_we  out  1  write (store) request
- mem_addr_sel  out  1  0=PC (instruction), 1=ALU result register (data)
- ir_we  out  1  latch instruction register
- ab_we  out  1  latch rs1/rs2/imm operand registers
- alu_out_we  out  1  latch ALU result register
- alu_a_sel  out  1  0=rs1, 1=PC
- alu_b_sel  out  2  0=rs2, 1=imm, 2=constant 4
- pc_we  out  1  update PC
- pc_src  out  2  0=PC+4, 1=ALU result register, 2=branch target
- reg_we  out  1  register-file write
- wb_sel  out  2  0=ALU result register, 1=memory data, 2=PC+4
- state  out  ctrl_state_t  current state, for debug
- trap  out  1  sticky trap flag
- trap_cause  out  2  0=none, 1=illegal, 2=bus timeout, 3=ECALL/EBREAK halt
- instret  out  INSTRET_WIDTH  retired-instruction count

Behaviour:
- Reset (rst_n low, any time, including mid-transaction):
  - state=IDLE, instret=0, trap=0, trap_cause=0, timeout counter=0.
  - Every control output is 0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- Outputs are combinational from the state register plus mnemonic, cond_jump and mem_ready. Any control not listed for a state is 0.
- IDLE: wait; go to FETCH when run=1.
- FETCH:
  - mem_req=1, mem_addr_sel=0.
  - When mem_ready=1: ir_we=1, go to DECODE.
- DECODE: ab_we=1, go to EXECUTE. An unsupported mnemonic goes to TRAP (cause 1) instead.
- EXECUTE:
  - alu_out_we=1; alu_a_sel and alu_b_sel are set per mnemonic:
    - AUIPC/JAL: a=PC, b=imm.
    - JALR: a=rs1, b=imm.
    - R-type: b=rs2.
    - I-type, load, store: b=imm.
  - Branches: pc_we=1, pc_src = cond_jump ? 2 : 0. Instruction retires here; next state FETCH.
  - Loads/stores: next state MEM.
  - ECALL/EBREAK: next state TRAP, cause 3.
  - All others: next state WRITEBACK.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for stores.
  - On mem_ready:
    - Load: go to WRITEBACK.
    - Store: pc_we=1, pc_src=0, retire, go to FETCH.
- WRITEBACK:
  - reg_we=1 and pc_we=1, then go to FETCH.
  - wb_sel: loads=1, JAL/JALR=2, others=0.
  - pc_src: JAL/JALR=1, others=0.
- Handshake:
  - mem_req stays asserted with stable mem_we and mem_addr_sel until mem_ready is sampled high.
  - The transfer completes in the same cycle mem_ready is seen.
  - mem_ready outside FETCH/MEM is ignored.
- Bus timeout:
  - The counter increments each FETCH/MEM cycle with mem_ready=0 and clears on a handshake or on leaving the state.
  - When the count reaches MEM_TIMEOUT−1 with mem_ready still 0, the next state is TRAP, cause 2.
  - mem_ready arriving on that same cycle wins: normal completion, no trap.
- TRAP:
  - trap=1, trap_cause held, all controls 0.
  - Exit only by reset; run is ignored.
- Retirement: instret increments by 1 on each retiring cycle (branch EXECUTE, store MEM ack, WRITEBACK). It wraps modulo 2^INSTRET_WIDTH.
- Latency with zero-wait memory:
  - branch 3 cycles.
  - ALU/LUI/AUIPC/JAL/JALR 4 cycles.
  - store 4 cycles.
  - load 5 cycles.
  - Each memory wait cycle adds 1.

Decomposition:
- be_pkg holds:
  - ctrl_state_t enum.
  - alu_a_sel_t, alu_b_sel_t, pc_src_t, wb_sel_t, trap_cause_t enums with the encodings above.
  - MEM_TIMEOUT default constant.
- The mnemonic-class helper functions (is_load, is_store, is_branch, is_jump, uses_imm) also live in be_pkg.
- One sub-module: bus_watchdog, the timeout counter with inputs active, ready and outputs expired.

Test Plan:
- Reset held low, then released with run=1, zero-wait memory, ADDI → states IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, FETCH; reg_we=1 only in WRITEBACK; instret=1 after 4 cycles.
- BEQ with cond_jump=1, then BNE with cond_jump=0 → pc_we in EXECUTE with pc_src=2, then pc_src=0; no reg_we; 3 cycles each.
- LW with mem_ready delayed 3 cycles in MEM → mem_req and mem_addr_sel=1 stable for 4 cycles; wb_sel=1 in WRITEBACK; total 8 cycles.
- MEM_TIMEOUT=4, FETCH with mem_ready=0 for 4 cycles → TRAP, trap_cause=2, mem_req deasserts. Same test with mem_ready=1 on the 4th cycle → DECODE, no trap.
- Unsupported mnemonic → TRAP, cause 1. EBREAK → TRAP, cause 3. In both cases run toggling has no effect and rst_n low returns to IDLE with all outputs 0.
- rst_n asserted mid-MEM store → mem_req and mem_we drop immediately (asynchronous); instret unchanged at 0 after reset.
